// File: rtl/tns_codec_27.sv
// rtl/tns_codec_27.sv - base-7 crosstalk-avoidance codec for a 27-TSV link.
// Optional macro TNS_DEC_REG_EN registers the decoder output on clock.
module tns_codec_27 (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [25:0] datain,
  output logic [26:0] tsv,
  input  logic [26:0] tsv_rx,
  output logic [25:0] dataout
);

  localparam logic [25:0] MAX_VAL = 26'd40353606;

  logic [26:0] tsv_q;
  logic [26:0] tsv_d;
  logic [25:0] enc_val;
  logic [2:0]  enc_dig;
  logic [2:0]  enc_grp;
  logic [25:0] dec_acc;
  logic [2:0]  dec_dig;

  // Digit split by repeated divide-by-7; digit 6 picks whichever pattern
  // keeps the group clear of the coupling case set by its current b2.
  always_comb begin
    tsv_d   = '0;
    enc_dig = '0;
    enc_grp = '0;
    enc_val = (datain > MAX_VAL) ? MAX_VAL : datain;
    for (int j = 0; j < 9; j++) begin
      enc_dig = 3'(enc_val % 26'd7);
      enc_val = enc_val / 26'd7;
      case (enc_dig)
        3'd0:    enc_grp = 3'b000;
        3'd1:    enc_grp = 3'b010;
        3'd2:    enc_grp = 3'b011;
        3'd3:    enc_grp = 3'b100;
        3'd4:    enc_grp = 3'b101;
        3'd5:    enc_grp = 3'b111;
        default: enc_grp = tsv_q[3*j+2] ? 3'b001 : 3'b110;
      endcase
      tsv_d[3*j +: 3] = enc_grp;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tsv_q <= '0;
    end else begin
      tsv_q <= tsv_d;
    end
  end

  assign tsv = tsv_q;

  // Horner evaluation from the most-significant group down.
  always_comb begin
    dec_acc = '0;
    dec_dig = '0;
    for (int j = 8; j >= 0; j--) begin
      case (tsv_rx[3*j +: 3])
        3'b000:  dec_dig = 3'd0;
        3'b010:  dec_dig = 3'd1;
        3'b011:  dec_dig = 3'd2;
        3'b100:  dec_dig = 3'd3;
        3'b101:  dec_dig = 3'd4;
        3'b111:  dec_dig = 3'd5;
        default: dec_dig = 3'd6;
      endcase
      dec_acc = dec_acc * 26'd7 + {23'd0, dec_dig};
    end
  end

`ifdef TNS_DEC_REG_EN
  logic [25:0] dataout_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      dataout_q <= '0;
    end else begin
      dataout_q <= dec_acc;
    end
  end

  assign dataout = dataout_q;
`else
  assign dataout = dec_acc;
`endif

endmodule

// File: tb/tb_tns_codec_27.sv
// tb/tb_tns_codec_27.sv - scoreboard bench for tns_codec_27 (honours TNS_DEC_REG_EN).
module tb_tns_codec_27;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [25:0] datain;
  logic [26:0] tsv;
  logic [26:0] tsv_rx;
  logic [26:0] rx_force;
  logic [25:0] dataout;
  logic        loop_en;
  logic        sb_en;

  always #5 clock = ~clock;

  assign tsv_rx = loop_en ? tsv : rx_force;

  tns_codec_27 dut (
    .clock   (clock),
    .reset_n (reset_n),
    .datain  (datain),
    .tsv     (tsv),
    .tsv_rx  (tsv_rx),
    .dataout (dataout)
  );

`ifdef TNS_DEC_REG_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif

  int checks = 0;
  int errors = 0;

  logic [25:0] dat_eq[$];
  logic [26:0] tsv_eq[$];
  bit          m_b2[9];
  logic [26:0] prev_tsv = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] pat(input int d, input bit b2);
    case (d)
      0:       return 3'b000;
      1:       return 3'b010;
      2:       return 3'b011;
      3:       return 3'b100;
      4:       return 3'b101;
      5:       return 3'b111;
      default: return b2 ? 3'b001 : 3'b110;
    endcase
  endfunction

  function automatic int dec_model(input logic [26:0] rx);
    int acc = 0;
    int p = 1;
    int d;
    logic [2:0] g;
    for (int j = 0; j < 9; j++) begin
      g = rx[3*j +: 3];
      case (g)
        3'b000:  d = 0;
        3'b010:  d = 1;
        3'b011:  d = 2;
        3'b100:  d = 3;
        3'b101:  d = 4;
        3'b111:  d = 5;
        default: d = 6;
      endcase
      acc += d * p;
      p *= 7;
    end
    return acc;
  endfunction

  task automatic model_push(input logic [25:0] v);
    int c;
    int d;
    logic [26:0] t;
    c = (int'(v) > 40353606) ? 40353606 : int'(v);
    dat_eq.push_back(26'(c));
    t = '0;
    for (int j = 0; j < 9; j++) begin
      d = c % 7;
      c = c / 7;
      t[3*j +: 3] = pat(d, m_b2[j]);
      m_b2[j] = t[3*j+2];
    end
    tsv_eq.push_back(t);
  endtask

  task automatic step(input logic [25:0] v);
    datain = v;
    @(posedge clock);
    if (sb_en) model_push(v);
    #2;
  endtask

  task automatic do_reset();
    sb_en = 1'b0;
    dat_eq.delete();
    tsv_eq.delete();
    loop_en = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    check("rst_tsv", 32'(tsv), 32'd0);
    check("rst_dout", 32'(dataout), 32'd0);
    for (int j = 0; j < 9; j++) m_b2[j] = 1'b0;
    reset_n = 1'b1;
    sb_en = 1'b1;
  endtask

  // Monitor: invariant on every cycle, scoreboard pops when output is due.
  always @(negedge clock) begin
    logic [2:0] g;
    bit bad;
    bad = 1'b0;
    for (int j = 0; j < 9; j++) begin
      g = tsv[3*j +: 3];
      if (g == 3'b001 && !prev_tsv[3*j+2]) bad = 1'b1;
      if (g == 3'b110 &&  prev_tsv[3*j+2]) bad = 1'b1;
    end
    check("invariant", {31'd0, bad}, 32'd0);
    prev_tsv = tsv;
    if (sb_en) begin
      if (tsv_eq.size() > 0) check("sb_tsv", 32'(tsv), 32'(tsv_eq.pop_front()));
      if (dat_eq.size() > DLY) check("sb_dout", 32'(dataout), 32'(dat_eq.pop_front()));
    end
  end

  logic [26:0] rx_list[6];

  initial begin
    reset_n  = 1'b0;
    datain   = '0;
    loop_en  = 1'b1;
    rx_force = '0;
    sb_en    = 1'b0;

    do_reset();
    step(26'd6);  check("alt6_a", 32'(tsv), 32'd6);
    step(26'd6);  check("alt6_b", 32'(tsv), 32'd1);
    step(26'd6);  check("alt6_c", 32'(tsv), 32'd6);

    do_reset();
    step(26'd7);        check("multi7", 32'(tsv), 32'd16);
    step(26'd40353606); check("all6_110", 32'(tsv), 32'(27'o666666666));
    step(26'd67108863); check("clamp_001", 32'(tsv), 32'(27'o111111111));
    step(26'd40353606); check("all6_110b", 32'(tsv), 32'(27'o666666666));
    step(26'd0);

    do_reset();
    step(26'd6);  check("hist_clear", 32'(tsv), 32'd6);
    step(26'd0);
    step(26'd0);

    sb_en = 1'b0;
    dat_eq.delete();
    tsv_eq.delete();
    loop_en = 1'b0;
    rx_list[0] = 27'b001;
    rx_list[1] = 27'b110;
    rx_list[2] = '1;
    rx_list[3] = '0;
    rx_list[4] = 27'($urandom);
    rx_list[5] = 27'($urandom);
    for (int i = 0; i < 6; i++) begin
      rx_force = rx_list[i];
`ifdef TNS_DEC_REG_EN
      @(posedge clock);
`endif
      #1;
      check("dec_only", 32'(dataout), 32'(dec_model(rx_list[i])));
    end
    loop_en = 1'b1;

    do_reset();
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 15) == 0) step(26'($urandom));
      else step(26'($urandom_range(0, 40353606)));
    end

    sb_en = 1'b0;
    repeat (2) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
